gfau_param: RTL and testbench
=============================

Name: gfau_param

Overview:
- Parametrised successor to the fixed 32-bit GFAU: a multi-cycle GF(p) arithmetic unit.
- Operations: add, subtract, multiply and divide on WIDTH-bit operands modulo a runtime prime.
- Uses a start/done/acknowledge handshake, and reports a divide-by-zero error that the previous unit did not have.
- Sits under the ECC point-arithmetic controller, which issues one operation at a time and acknowledges each result.

Parameters:
- WIDTH, 32: operand, prime and result width in bits (≥ 8).
- ITER_W, $clog2(2*WIDTH+2): width of the internal iteration counter.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, asynchronous, active-low
- i_start  input  1  one-cycle request; sampled only in IDLE or DONE
- in_0  input  WIDTH  operand a; must be < prime
- in_1  input  WIDTH  operand b; must be < prime
- prime  input  WIDTH  odd prime modulus p, p ≥ 3
- operation_select  input  2  0=ADD, 1=SUB, 2=MULT, 3=DIV
- done_from_control  input  1  controller acknowledge of the result
- result  output  WIDTH  registered result, held while done_to_control=1
- o_busy  output  1  operation in progress
- done_to_control  output  1  result valid; level signal held until acknowledged
- done_add / done_sub / done_mult / done_div  output  1 each  one-hot copy of done_to_control by operation
- o_err  output  1  DIV with b==0; valid only while done_to_control=1

Behaviour:
- Reset (i_rst=0, asynchronous): all outputs are 0, state=IDLE, all internal registers cleared. Reset mid-operation aborts the operation with no result.
- Operand capture: a, b, p and op are registered on the cycle a start is accepted; input changes while busy are ignored.
- States and transitions:
  - IDLE: accepts i_start.
  - EXEC_AS: ADD/SUB.
  - MUL: serial multiply.
  - INV: binary extended-Euclid inversion.
  - DONE: holds the result.
- ADD: s=a+b computed at WIDTH+1 bits; if s≥p, s-=p. start→done latency is 2 cycles: accept, EXEC_AS, then DONE.
- SUB: d=a-b; if borrow, d+=p. Latency 2 cycles.
- MULT: MSB-first interleaved multiply, one bit per cycle for WIDTH cycles. Each step is r=(2r mod p), then if b[i], r=(r+a mod p), using WIDTH+1-bit intermediates. Latency WIDTH+2 cycles.
- DIV: result = a·b⁻¹ mod p.
  - INV runs binary inversion with u=b, v=p, x1=1, x2=0. Halving is x odd ? (x+p)>>1 : x>>1, at WIDTH+1 bits. INV ends when u==1 (inverse x1) or v==1 (inverse x2).
  - INV is hard-capped at 2·WIDTH iterations, then the unit enters MUL with operands (a, inverse).
  - Total latency ≤ 3·WIDTH+3 cycles; the exact count is data-dependent.
- DIV with b==0: INV is skipped; DONE is entered one cycle after accept with result=0, o_err=1 and done_div=1.
- Done flags: done_to_control and exactly one done_* are 1 in DONE only; o_busy=1 in EXEC_AS, MUL and INV.
- done_from_control=1 in DONE returns the unit to IDLE next cycle and clears result to 0 and o_err to 0. The acknowledge is ignored in any other state.
- i_start while busy is ignored: no queueing, no error.
- i_start and done_from_control in the same DONE cycle: the ack is honoured, the new operation is accepted, done drops and o_busy rises next cycle.
- i_start alone in DONE without an ack is ignored.
- Out-of-range operands (≥p) or non-prime p give an undefined result, but the unit must still terminate within the latency bound and never hang.

Optional Feature:
- Macro: GFAU_DIV_EN.
- Defined: DIV is implemented as above.
- Undefined: INV logic is not synthesised. DIV enters DONE one cycle after accept with result=0, o_err=1 and done_div=1; ADD, SUB and MULT are unchanged.

Decomposition:
- Package gfau_pkg holds:
  - the op encoding constants OP_ADD, OP_SUB, OP_MULT, OP_DIV;
  - the state enum (IDLE, EXEC_AS, MUL, INV, DONE);
  - a mod_add / mod_sub function pair, shared by the top level and the sub-module.
- Sub-module gfau_mod_mul: the serial WIDTH-cycle modular multiplier with start/done. It is shared by MULT and the final step of DIV.

Test Plan:
- p=97: ADD 50+60 → result=13, done_add=1, 2 cycles after start. SUB 5-9 → 93, done_sub=1.
- p=97: MULT 12×13 → 59, done_mult=1, exactly WIDTH+2 cycles after start. DIV 10/3 → 68, done_div=1, o_err=0.
- p=0xFFFFFFFB (WIDTH=32): ADD (p-1)+(p-1) → 0xFFFFFFF9. MULT (p-1)×(p-1) → 1. DIV 1/2 → 0x7FFFFFFE.
- DIV 7/0 at p=97 → result=0, o_err=1, done_div=1, 1 cycle after accept. Repeat with GFAU_DIV_EN undefined: DIV 10/3 → result=0, o_err=1.
- Handshake:
  - Hold done_from_control=0 for 20 cycles: result and done stay stable.
  - i_start pulsed mid-MULT: ignored.
  - ack and start in the same cycle: next op (ADD 1+1 → 2) completes correctly.
- Assert i_rst=0 mid-DIV: all outputs go to 0 immediately. After release, ADD 3+4 at p=97 → 7.

Source files
------------

// File: rtl/gfau_pkg.sv
// gfau_pkg: op codes, FSM states and the modular add/sub helpers shared by the GF(p) unit.
// Helpers work at GF_MAX_W bits; callers zero-extend operands and truncate results.
package gfau_pkg;
  localparam int GF_MAX_W = 256;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MULT = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;
  typedef enum logic [2:0] {IDLE, EXEC_AS, MUL, INV, DONE} gf_state_t;
  function automatic logic [GF_MAX_W-1:0] mod_add(input logic [GF_MAX_W-1:0] a, input logic [GF_MAX_W-1:0] b,
                                                   input logic [GF_MAX_W-1:0] p);
    logic [GF_MAX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, p}) ? GF_MAX_W'(s - {1'b0, p}) : s[GF_MAX_W-1:0];
  endfunction
  function automatic logic [GF_MAX_W-1:0] mod_sub(input logic [GF_MAX_W-1:0] a, input logic [GF_MAX_W-1:0] b,
                                                   input logic [GF_MAX_W-1:0] p);
    logic [GF_MAX_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[GF_MAX_W] ? GF_MAX_W'(d + {1'b0, p}) : d[GF_MAX_W-1:0];
  endfunction
endpackage

// File: rtl/gfau_mod_mul.sv
// gfau_mod_mul: serial MSB-first interleaved modular multiplier, one bit of b per cycle.
module gfau_mod_mul
  import gfau_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER_W = $clog2(2*WIDTH+2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             done,
  output logic [WIDTH-1:0] r
);
  logic [WIDTH-1:0] a_q, b_q, p_q, r_dbl, r_nx;
  logic [ITER_W-1:0] cnt;
  logic run;
  assign r_dbl = WIDTH'(mod_add(GF_MAX_W'(r), GF_MAX_W'(r), GF_MAX_W'(p_q)));
  assign r_nx = b_q[WIDTH-1] ? WIDTH'(mod_add(GF_MAX_W'(r_dbl), GF_MAX_W'(a_q), GF_MAX_W'(p_q))) : r_dbl;
  assign done = run && cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      r <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      a_q <= a;
      b_q <= b;
      p_q <= p;
      r <= '0;
      cnt <= ITER_W'(WIDTH);
      run <= 1'b1;
    end else if (cnt != '0) begin
      r <= r_nx;
      b_q <= b_q << 1;
      cnt <= cnt - 1'b1;
    end else begin
      run <= 1'b0;
    end
  end
endmodule

// File: rtl/gfau_param.sv
// gfau_param: multi-cycle GF(p) add/sub/mul/div unit with start/done/acknowledge handshake.
// Inversion for DIV is built only when GFAU_DIV_EN is defined; otherwise DIV returns o_err.
module gfau_param
  import gfau_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER_W = $clog2(2*WIDTH+2)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] prime,
  input  logic [1:0]       operation_select,
  input  logic             done_from_control,
  output logic [WIDTH-1:0] result,
  output logic             o_busy,
  output logic             done_to_control,
  output logic             done_add,
  output logic             done_sub,
  output logic             done_mult,
  output logic             done_div,
  output logic             o_err
);
  gf_state_t state, state_nx, entry;
  logic [WIDTH-1:0] a_q, b_q, p_q, inv, mul_r;
  logic [1:0] op_q;
  logic accept, inv_end, mul_start, mul_done, div_err;
  assign accept = i_start && (state == IDLE || (state == DONE && done_from_control));
`ifdef GFAU_DIV_EN
  assign div_err = in_1 == '0;
`else
  assign div_err = 1'b1;
`endif
  assign entry = operation_select == OP_MULT ? MUL :
                 operation_select == OP_DIV ? (div_err ? DONE : INV) : EXEC_AS;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? entry : IDLE;
      EXEC_AS: state_nx = DONE;
      MUL:     state_nx = mul_done ? DONE : MUL;
      INV:     state_nx = inv_end ? MUL : INV;
      DONE:    state_nx = accept ? entry : done_from_control ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      op_q <= OP_ADD;
      result <= '0;
      o_err <= 1'b0;
    end else if (accept) begin
      a_q <= in_0;
      b_q <= in_1;
      p_q <= prime;
      op_q <= operation_select;
      result <= '0;
      o_err <= operation_select == OP_DIV && div_err;
    end else if (state == EXEC_AS) begin
      result <= op_q == OP_ADD ? WIDTH'(mod_add(GF_MAX_W'(a_q), GF_MAX_W'(b_q), GF_MAX_W'(p_q)))
                               : WIDTH'(mod_sub(GF_MAX_W'(a_q), GF_MAX_W'(b_q), GF_MAX_W'(p_q)));
    end else if (state == MUL && mul_done) begin
      result <= mul_r;
    end else if (state == DONE && done_from_control) begin
      result <= '0;
      o_err <= 1'b0;
    end
  end
`ifdef GFAU_DIV_EN
  logic [WIDTH-1:0] u, v, x1, x2;
  logic [ITER_W-1:0] cnt;
  function automatic logic [WIDTH-1:0] half(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] s;
    s = x[0] ? {1'b0, x} + {1'b0, p_q} : {1'b0, x};
    return s[WIDTH:1];
  endfunction
  function automatic logic [WIDTH-1:0] msub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return WIDTH'(mod_sub(GF_MAX_W'(x), GF_MAX_W'(y), GF_MAX_W'(p_q)));
  endfunction
  // Invariants x1*b == u and x2*b == v (mod p); subtract-and-halve keeps u*v shrinking each cycle.
  assign inv_end = state == INV && (u == WIDTH'(1) || v == WIDTH'(1) || cnt == ITER_W'(2*WIDTH));
  assign inv = u == WIDTH'(1) ? x1 : x2;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      u <= '0;
      v <= '0;
      x1 <= '0;
      x2 <= '0;
      cnt <= '0;
    end else if (accept) begin
      u <= in_1;
      v <= prime;
      x1 <= WIDTH'(1);
      x2 <= '0;
      cnt <= '0;
    end else if (state == INV && !inv_end) begin
      if (!u[0]) begin
        u <= u >> 1;
        x1 <= half(x1);
      end else if (!v[0]) begin
        v <= v >> 1;
        x2 <= half(x2);
      end else if (u >= v) begin
        u <= (u - v) >> 1;
        x1 <= half(msub(x1, x2));
      end else begin
        v <= (v - u) >> 1;
        x2 <= half(msub(x2, x1));
      end
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign inv_end = 1'b0;
  assign inv = '0;
`endif
  assign mul_start = (accept && operation_select == OP_MULT) || inv_end;
  gfau_mod_mul #(.WIDTH(WIDTH), .ITER_W(ITER_W)) u_mul (
    .clk(i_clk),
    .rst_n(i_rst),
    .start(mul_start),
    .a(inv_end ? a_q : in_0),
    .b(inv_end ? inv : in_1),
    .p(inv_end ? p_q : prime),
    .done(mul_done),
    .r(mul_r)
  );
  assign o_busy = state == EXEC_AS || state == MUL || state == INV;
  assign done_to_control = state == DONE;
  assign done_add = done_to_control && op_q == OP_ADD;
  assign done_sub = done_to_control && op_q == OP_SUB;
  assign done_mult = done_to_control && op_q == OP_MULT;
  assign done_div = done_to_control && op_q == OP_DIV;
endmodule

// File: tb/tb_gfau_param.sv
// tb_gfau_param: directed checks of gfau_param arithmetic, latency, handshake and reset (WIDTH=32).
module tb_gfau_param;
  import gfau_pkg::*;
  localparam logic [31:0] PB = 32'hFFFF_FFFB;
  logic clk = 1'b0, i_rst = 1'b0, i_start = 1'b0, ack = 1'b0;
  logic [31:0] in_0 = '0, in_1 = '0, prime = '0;
  logic [1:0] op = '0;
  logic [31:0] result;
  logic o_busy, done_to_control, done_add, done_sub, done_mult, done_div, o_err;
  logic [3:0] flags;
  int tests = 0, fails = 0, lat = 0, bad = 0;
  logic busy_seen;
  assign flags = {done_add, done_sub, done_mult, done_div};
  always #5 clk = ~clk;
  gfau_param #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .in_0(in_0), .in_1(in_1), .prime(prime),
    .operation_select(op), .done_from_control(ack), .result(result), .o_busy(o_busy),
    .done_to_control(done_to_control), .done_add(done_add), .done_sub(done_sub),
    .done_mult(done_mult), .done_div(done_div), .o_err(o_err)
  );
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  // Drives one operation; optionally pulses a junk start at cycle poke while the unit is busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input int poke);
    @(negedge clk);
    op = o; in_0 = a; in_1 = b; prime = p; i_start = 1'b1;
    lat = 0; busy_seen = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      i_start = (poke != 0 && lat == poke);
      if (i_start) begin op = OP_ADD; in_0 = 32'd1; in_1 = 32'd1; end
      if (!done_to_control && !o_busy) busy_seen = 1'b0;
    end while (!done_to_control && lat < 200);
    i_start = 1'b0;
  endtask
  task automatic do_ack();
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1; ack = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++; if ({result, o_busy, done_to_control, flags, o_err} !== '0) begin fails++; $display("FAIL reset_outputs: got %h/%b/%b/%b/%b exp all zero", result, o_busy, done_to_control, flags, o_err); end
    @(negedge clk); i_rst = 1'b1;
  endtask
  task automatic test_add_sub();
    run_op(OP_ADD, 32'd50, 32'd60, 32'd97, 0);
    tests++; if (result !== 32'd13) begin fails++; $display("FAIL add_res: got %0d exp 13", result); end
    tests++; if (flags !== 4'b1000 || o_err !== 1'b0) begin fails++; $display("FAIL add_flags: got %b err %b exp 1000 err 0", flags, o_err); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL add_lat: got %0d exp 2", lat); end
    do_ack();
    tests++; if ({result, done_to_control, o_busy} !== '0) begin fails++; $display("FAIL ack_clear: got %h/%b/%b exp 0/0/0", result, done_to_control, o_busy); end
    run_op(OP_SUB, 32'd5, 32'd9, 32'd97, 0);
    tests++; if (result !== 32'd93) begin fails++; $display("FAIL sub_res: got %0d exp 93", result); end
    tests++; if (flags !== 4'b0100 || lat !== 2) begin fails++; $display("FAIL sub_flags_lat: got %b/%0d exp 0100/2", flags, lat); end
    do_ack();
  endtask
  task automatic test_mult();
    run_op(OP_MULT, 32'd12, 32'd13, 32'd97, 0);
    tests++; if (result !== 32'd59) begin fails++; $display("FAIL mult_res: got %0d exp 59", result); end
    tests++; if (flags !== 4'b0010) begin fails++; $display("FAIL mult_flags: got %b exp 0010", flags); end
    tests++; if (lat !== 34 || busy_seen !== 1'b1) begin fails++; $display("FAIL mult_lat: got %0d busy %b exp 34 busy 1", lat, busy_seen); end
    do_ack();
  endtask
  task automatic test_div();
`ifdef GFAU_DIV_EN
    run_op(OP_DIV, 32'd10, 32'd3, 32'd97, 0);
    tests++; if (result !== 32'd68 || o_err !== 1'b0) begin fails++; $display("FAIL div_res: got %0d err %b exp 68 err 0", result, o_err); end
    tests++; if (lat < 2 || lat > 99) begin fails++; $display("FAIL div_lat: got %0d exp 2..99", lat); end
`else
    run_op(OP_DIV, 32'd10, 32'd3, 32'd97, 0);
    tests++; if (result !== 32'd0 || o_err !== 1'b1) begin fails++; $display("FAIL div_res: got %0d err %b exp 0 err 1", result, o_err); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL div_lat: got %0d exp 1", lat); end
`endif
    tests++; if (flags !== 4'b0001) begin fails++; $display("FAIL div_flags: got %b exp 0001", flags); end
    do_ack();
    run_op(OP_DIV, 32'd7, 32'd0, 32'd97, 0);
    tests++; if (result !== 32'd0 || o_err !== 1'b1 || flags !== 4'b0001) begin fails++; $display("FAIL div0: got %0d err %b flags %b exp 0 err 1 flags 0001", result, o_err, flags); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL div0_lat: got %0d exp 1", lat); end
    do_ack();
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL div0_err_clear: got %b exp 0", o_err); end
  endtask
  task automatic test_big_prime();
    run_op(OP_ADD, PB - 1, PB - 1, PB, 0);
    tests++; if (result !== 32'hFFFF_FFF9) begin fails++; $display("FAIL big_add: got %h exp fffffff9", result); end
    do_ack();
    run_op(OP_MULT, PB - 1, PB - 1, PB, 0);
    tests++; if (result !== 32'd1 || lat !== 34) begin fails++; $display("FAIL big_mult: got %h lat %0d exp 1 lat 34", result, lat); end
    do_ack();
    run_op(OP_DIV, 32'd1, 32'd2, PB, 0);
`ifdef GFAU_DIV_EN
    tests++; if (result !== 32'h7FFF_FFFE || o_err !== 1'b0 || lat > 99) begin fails++; $display("FAIL big_div: got %h err %b lat %0d exp 7ffffffe err 0 lat<=99", result, o_err, lat); end
`else
    tests++; if (result !== 32'd0 || o_err !== 1'b1) begin fails++; $display("FAIL big_div: got %h err %b exp 0 err 1", result, o_err); end
`endif
    do_ack();
  endtask
  task automatic test_hold();
    run_op(OP_ADD, 32'd20, 32'd30, 32'd97, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      i_start = (i == 5);
      op = OP_SUB; in_0 = 32'd1; in_1 = 32'd2;
      @(posedge clk); #1;
      if (result !== 32'd50 || done_to_control !== 1'b1 || flags !== 4'b1000 || o_busy !== 1'b0) bad++;
    end
    i_start = 1'b0;
    tests++; if (bad !== 0) begin fails++; $display("FAIL hold_stable: got %0d unstable cycles exp 0", bad); end
    do_ack();
  endtask
  task automatic test_start_mid_mult();
    run_op(OP_MULT, 32'd12, 32'd13, 32'd97, 5);
    tests++; if (result !== 32'd59 || flags !== 4'b0010) begin fails++; $display("FAIL mid_start_res: got %0d flags %b exp 59 flags 0010", result, flags); end
    tests++; if (lat !== 34 || busy_seen !== 1'b1) begin fails++; $display("FAIL mid_start_lat: got %0d busy %b exp 34 busy 1", lat, busy_seen); end
  endtask
  task automatic test_back_to_back();
    @(negedge clk);
    ack = 1'b1; i_start = 1'b1; op = OP_ADD; in_0 = 32'd1; in_1 = 32'd1; prime = 32'd97;
    @(posedge clk); #1;
    ack = 1'b0; i_start = 1'b0;
    tests++; if ({done_to_control, o_busy} !== 2'b01) begin fails++; $display("FAIL b2b_accept: got done %b busy %b exp 0 1", done_to_control, o_busy); end
    @(posedge clk); #1;
    tests++; if (result !== 32'd2 || flags !== 4'b1000) begin fails++; $display("FAIL b2b_res: got %0d flags %b exp 2 flags 1000", result, flags); end
    do_ack();
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    op = OP_DIV; in_0 = 32'd10; in_1 = 32'd3; prime = 32'd97; i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    repeat (2) @(posedge clk);
    #2; i_rst = 1'b0;
    #1;
    tests++; if ({result, o_busy, done_to_control, flags, o_err} !== '0) begin fails++; $display("FAIL reset_mid: got %h/%b/%b/%b/%b exp all zero", result, o_busy, done_to_control, flags, o_err); end
    @(negedge clk); i_rst = 1'b1;
    run_op(OP_ADD, 32'd3, 32'd4, 32'd97, 0);
    tests++; if (result !== 32'd7 || lat !== 2) begin fails++; $display("FAIL post_reset_add: got %0d lat %0d exp 7 lat 2", result, lat); end
    do_ack();
  endtask
  initial begin
    test_reset();
    test_add_sub();
    test_mult();
    test_div();
    test_big_prime();
    test_hold();
    test_start_mid_mult();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
